// File: rtl/card_dat_responder.sv
// Card-side DAT line engine for single-bit SD-style block transfers.
// Write path: wait for the host start bit and receive data plus CRC16. Then
// turn the line around, send a CRC status token and hold busy low.
// Read path: fetch a payload word and send a start bit, the data, the CRC16,
// an end bit and an inter-block gap. Both paths repeat for multi-block transfers.
//
// Frame on the wire: start 0, 32 data bits MSB first, CRC16 MSB first
// (x^16+x^12+x^5+1, seed 0, data bits only), end 1.
//
// tx handshake: a word moves on the rising edge where tx_valid && tx_ready.
// tx_ready depends only on state (and abort), never on tx_valid. The source
// holds tx_data stable while tx_valid is high and the word is not yet taken.
module card_dat_responder #(
    parameter int BUSY_CYCLES = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    input  logic        start_write,
    input  logic        start_read,
    input  logic        multiple,
    input  logic [3:0]  blocks,
    input  logic        abort,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        crc_error,
    output logic        timeout_error,
    output logic        done,
    output logic        busy,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RX_WAIT  = 4'd1,
        RX_DATA  = 4'd2,
        RX_CRC   = 4'd3,
        RX_END   = 4'd4,
        TURN     = 4'd5,
        TOKEN    = 4'd6,
        BUSY     = 4'd7,
        TX_FETCH = 4'd8,
        TX_DATA  = 4'd9,
        TX_CRC   = 4'd10,
        TX_END   = 4'd11,
        TX_GAP   = 4'd12
    } state_t;

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]      BUSY_LAST  = 6'(BUSY_CYCLES - 1);
    localparam logic [15:0]     CRC_POLY   = 16'h1021;
    localparam logic [4:0]      TOKEN_GOOD = 5'b00101;
    localparam logic [4:0]      TOKEN_BAD  = 5'b01011;

    state_t        state;
    state_t        state_next;
    logic [5:0]    bit_cnt;
    logic [4:0]    blk_cnt;
    logic [TW-1:0] timer;
    logic [15:0]   crc;
    logic [15:0]   rcv_crc;
    logic [31:0]   rx_shift;
    logic [31:0]   tx_shift;
    logic          multiple_q;
    logic [3:0]    blocks_q;
    logic          fetched;
    logic          crc_ok;
    logic          blk_done;
    logic          rx_good;
    logic [4:0]    target;
    logic          more_blocks;
    logic [4:0]    token_pat;

    // One serial CRC16 step: shift left, fold in the polynomial on feedback.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    // A single block is implied when multi-block is off or the count is zero.
    assign target      = (!multiple_q || blocks_q == 4'd0) ? 5'd1 : {1'b0, blocks_q};
    assign more_blocks = (blk_cnt + 5'd1) < target;
    assign rx_good     = (crc == rcv_crc) && dat_in;
    assign token_pat   = crc_ok ? TOKEN_GOOD : TOKEN_BAD;
    assign rx_data     = rx_shift;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

    // State register.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pad/pulse outputs; abort overrides everything at the end.
    always_comb begin
        state_next    = state;
        dat_oe        = 1'b0;
        dat_out       = 1'b1;
        tx_ready      = 1'b0;
        rx_valid      = 1'b0;
        crc_error     = 1'b0;
        timeout_error = 1'b0;
        done          = 1'b0;
        blk_done      = 1'b0;
        case (state)
            IDLE: begin
                if (start_write) begin
                    state_next = RX_WAIT;
                end else if (start_read) begin
                    state_next = TX_FETCH;
                end
            end
            RX_WAIT: begin
                if (!dat_in) begin
                    state_next = RX_DATA;
                end else if (timer == TIMER_LAST) begin
                    timeout_error = 1'b1;
                    state_next    = IDLE;
                end
            end
            RX_DATA: begin
                if (bit_cnt == 6'd31) begin
                    state_next = RX_CRC;
                end
            end
            RX_CRC: begin
                if (bit_cnt == 6'd15) begin
                    state_next = RX_END;
                end
            end
            RX_END: begin
                if (rx_good) begin
                    rx_valid = 1'b1;
                end else begin
                    crc_error = 1'b1;
                end
                state_next = TURN;
            end
            TURN: begin
                if (bit_cnt == 6'd1) begin
                    state_next = TOKEN;
                end
            end
            TOKEN: begin
                dat_oe  = 1'b1;
                dat_out = token_pat[3'd4 - bit_cnt[2:0]];
                if (bit_cnt == 6'd4) begin
                    if (crc_ok) begin
                        state_next = BUSY;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            BUSY: begin
                dat_oe  = 1'b1;
                dat_out = 1'b0;
                if (bit_cnt == BUSY_LAST) begin
                    blk_done = 1'b1;
                    if (more_blocks) begin
                        state_next = RX_WAIT;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            TX_FETCH: begin
                // First phase waits for a word; second phase is the start bit.
                if (!fetched) begin
                    tx_ready = 1'b1;
                end else begin
                    dat_oe     = 1'b1;
                    dat_out    = 1'b0;
                    state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                dat_oe  = 1'b1;
                dat_out = tx_shift[31];
                if (bit_cnt == 6'd31) begin
                    state_next = TX_CRC;
                end
            end
            TX_CRC: begin
                dat_oe  = 1'b1;
                dat_out = crc[15];
                if (bit_cnt == 6'd15) begin
                    state_next = TX_END;
                end
            end
            TX_END: begin
                dat_oe     = 1'b1;
                dat_out    = 1'b1;
                state_next = TX_GAP;
            end
            TX_GAP: begin
                dat_oe  = 1'b1;
                dat_out = 1'b1;
                if (bit_cnt == 6'd1) begin
                    blk_done = 1'b1;
                    if (more_blocks) begin
                        state_next = TX_FETCH;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort) begin
            state_next    = IDLE;
            tx_ready      = 1'b0;
            rx_valid      = 1'b0;
            crc_error     = 1'b0;
            timeout_error = 1'b0;
            done          = 1'b0;
            blk_done      = 1'b0;
        end
    end

    // Counters, shift registers and CRC datapath.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            blk_cnt    <= '0;
            timer      <= '0;
            crc        <= '0;
            rcv_crc    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            multiple_q <= 1'b0;
            blocks_q   <= '0;
            fetched    <= 1'b0;
            crc_ok     <= 1'b0;
        end else begin
            // Bit counter restarts on every state change.
            if (state == IDLE || state_next != state) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            // Timeout counter only runs while waiting for a start bit.
            if (state == RX_WAIT && state_next == RX_WAIT) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            // Transfer shape is sampled continuously in IDLE, so it is frozen on exit.
            if (state == IDLE) begin
                multiple_q <= multiple;
                blocks_q   <= blocks;
                blk_cnt    <= '0;
            end else if (blk_done) begin
                blk_cnt <= blk_cnt + 5'd1;
            end

            if (state == TX_FETCH && !fetched) begin
                fetched <= tx_valid && tx_ready;
            end else begin
                fetched <= 1'b0;
            end

            if (tx_valid && tx_ready) begin
                tx_shift <= tx_data;
            end else if (state == TX_DATA) begin
                tx_shift <= {tx_shift[30:0], 1'b0};
            end

            case (state)
                IDLE, RX_WAIT, TX_FETCH: begin
                    crc     <= '0;
                    rcv_crc <= '0;
                end
                RX_DATA: begin
                    rx_shift <= {rx_shift[30:0], dat_in};
                    crc      <= crc_step(crc, dat_in);
                end
                RX_CRC: begin
                    rcv_crc <= {rcv_crc[14:0], dat_in};
                end
                RX_END: begin
                    crc_ok <= rx_good;
                end
                TX_DATA: begin
                    crc <= crc_step(crc, tx_shift[31]);
                end
                TX_CRC: begin
                    crc <= {crc[14:0], 1'b0};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_card_dat_responder.sv
// Directed bench for card_dat_responder: write, CRC error, multi-block write,
// multi-block read, start-bit timeout, abort and mid-transfer reset.
module tb_card_dat_responder;

    localparam int BUSY_CYCLES = 8;
    localparam int TIMEOUT     = 1024;

    logic        sd_clock = 1'b0;
    logic        reset;
    logic        dat_in;
    logic        dat_out;
    logic        dat_oe;
    logic        start_write;
    logic        start_read;
    logic        multiple;
    logic [3:0]  blocks;
    logic        abort;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        crc_error;
    logic        timeout_error;
    logic        done;
    logic        busy;
    logic [3:0]  state_dbg;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    card_dat_responder #(.BUSY_CYCLES(BUSY_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .dat_in        (dat_in),
        .dat_out       (dat_out),
        .dat_oe        (dat_oe),
        .start_write   (start_write),
        .start_read    (start_read),
        .multiple      (multiple),
        .blocks        (blocks),
        .abort         (abort),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .crc_error     (crc_error),
        .timeout_error (timeout_error),
        .done          (done),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // Clock.
    always #5 sd_clock = ~sd_clock;

    // Watchdog against a stuck run.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // Reference CRC16 (x^16+x^12+x^5+1, seed 0, MSB first).
    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic step();
        @(negedge sd_clock);
        #1;
    endtask

    task automatic begin_write();
        start_write = 1'b1;
        step();
        start_write = 1'b0;
        check("enter_rx_wait", state_dbg, 4'd1);
    endtask

    // Host side of one write block, entered with the DUT in RX_WAIT.
    task automatic send_block(input logic [31:0] data, input logic [15:0] flip, input bit good);
        logic [15:0] fcs;
        fcs = crc16(data) ^ flip;
        check("rx_wait_line", {dat_oe, dat_out}, 2'b01);
        if (good) exp_q.push_back(data);
        dat_in = 1'b0;
        step();
        for (int i = 31; i >= 0; i--) begin
            dat_in = data[i];
            step();
        end
        for (int i = 15; i >= 0; i--) begin
            dat_in = fcs[i];
            step();
        end
        dat_in = 1'b1;
        #1;
        check("rx_valid", rx_valid, good);
        check("crc_error", crc_error, !good);
        if (good) check("rx_data", rx_data, exp_q.pop_front());
        step();
    endtask

    // Card reply after a write block: turnaround, token, optional busy.
    task automatic reply(input bit good, input bit last);
        logic [4:0] tok;
        logic       oe_all;
        int         low_cnt;
        tok     = '0;
        oe_all  = 1'b1;
        low_cnt = 0;
        for (int j = 0; j < 2; j++) begin
            check("turn_line", {dat_oe, dat_out}, 2'b01);
            step();
        end
        for (int j = 0; j < 5; j++) begin
            tok    = {tok[3:0], dat_out};
            oe_all = oe_all & dat_oe;
            if (j == 4) check("token_done", done, !good);
            step();
        end
        check("token_bits", tok, good ? 5'b00101 : 5'b01011);
        check("token_oe", oe_all, 1'b1);
        if (good) begin
            for (int j = 0; j < BUSY_CYCLES; j++) begin
                if (dat_oe && !dat_out) low_cnt++;
                if (j == BUSY_CYCLES - 1) check("busy_done", done, last);
                step();
            end
            check("busy_low_cycles", low_cnt, BUSY_CYCLES);
        end
        if (good && !last) check("next_rx_wait", state_dbg, 4'd1);
        else check("back_idle", {busy, dat_oe}, 2'b00);
    endtask

    // Host side of one read block, entered with the DUT in TX_FETCH.
    task automatic recv_block(input logic [31:0] word, input bit last);
        logic [31:0] got;
        logic [15:0] got_crc;
        logic        oe_all;
        int          waitc;
        tx_data = word;
        exp_q.push_back(word);
        waitc = 0;
        while (!tx_ready && waitc < 20) begin
            step();
            waitc++;
        end
        check("tx_ready", tx_ready, 1'b1);
        step();
        check("tx_start", {dat_oe, dat_out}, 2'b10);
        check("tx_ready_low", tx_ready, 1'b0);
        step();
        got     = '0;
        got_crc = '0;
        oe_all  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            got    = {got[30:0], dat_out};
            oe_all = oe_all & dat_oe;
            step();
        end
        for (int i = 0; i < 16; i++) begin
            got_crc = {got_crc[14:0], dat_out};
            oe_all  = oe_all & dat_oe;
            step();
        end
        check("tx_end", {dat_oe, dat_out}, 2'b11);
        step();
        check("tx_gap0", {dat_oe, dat_out, done}, 3'b110);
        step();
        check("tx_gap1", {dat_oe, dat_out, done}, {2'b11, last});
        step();
        check("tx_oe", oe_all, 1'b1);
        check("tx_word", got, exp_q.pop_front());
        check("tx_crc", got_crc, crc16(word));
    endtask

    initial begin
        int waitc;
        reset       = 1'b1;
        dat_in      = 1'b1;
        start_write = 1'b0;
        start_read  = 1'b0;
        multiple    = 1'b0;
        blocks      = 4'd0;
        abort       = 1'b0;
        tx_data     = 32'h0;
        tx_valid    = 1'b0;

        // Reset values.
        #12;
        check("rst_line", {dat_oe, dat_out}, 2'b01);
        check("rst_flags", {busy, tx_ready, rx_valid, crc_error, timeout_error, done}, 6'b0);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_state", state_dbg, 4'd0);
        step();
        reset = 1'b0;
        step();

        // Single good write.
        begin_write();
        send_block(32'hA5A5_0F0F, 16'h0000, 1'b1);
        reply(1'b1, 1'b1);

        // Both starts high: write wins; then a corrupted CRC.
        start_read = 1'b1;
        begin_write();
        start_read = 1'b0;
        send_block(32'hA5A5_0F0F, 16'h0008, 1'b0);
        reply(1'b0, 1'b1);
        step();

        // Two-block write; block count is frozen once IDLE is left.
        multiple = 1'b1;
        blocks   = 4'd2;
        begin_write();
        blocks   = 4'd9;
        send_block(32'h1234_5678, 16'h0000, 1'b1);
        reply(1'b1, 1'b0);
        send_block(32'hFFFF_0000, 16'h0000, 1'b1);
        reply(1'b1, 1'b1);
        multiple = 1'b0;
        blocks   = 4'd0;
        step();

        // Three-block read with tx_valid always high.
        multiple   = 1'b1;
        blocks     = 4'd3;
        tx_valid   = 1'b1;
        start_read = 1'b1;
        step();
        start_read = 1'b0;
        multiple   = 1'b0;
        check("enter_tx_fetch", state_dbg, 4'd8);
        recv_block(32'hDEAD_BEEF, 1'b0);
        recv_block(32'h0000_0001, 1'b0);
        recv_block(32'h8000_0000, 1'b1);
        check("read_idle", {busy, tx_ready}, 2'b00);
        blocks = 4'd0;
        step();

        // No start bit: timeout after TIMEOUT cycles in RX_WAIT.
        begin_write();
        waitc = 1;
        while (!timeout_error && waitc < TIMEOUT + 100) begin
            step();
            waitc++;
        end
        check("timeout_cycles", waitc, TIMEOUT);
        check("timeout_pulse", timeout_error, 1'b1);
        step();
        check("timeout_idle", {busy, timeout_error}, 2'b00);

        // Abort on the tenth TX_DATA cycle.
        start_read = 1'b1;
        step();
        start_read = 1'b0;
        step();
        step();
        for (int i = 0; i < 9; i++) step();
        check("abort_in_tx_data", state_dbg, 4'd9);
        abort = 1'b1;
        #1;
        check("abort_no_done", {done, busy}, 2'b01);
        step();
        abort = 1'b0;
        check("abort_line", {busy, dat_oe, dat_out, done}, 4'b0010);
        check("abort_state", state_dbg, 4'd0);
        start_read = 1'b1;
        step();
        start_read = 1'b0;
        recv_block(32'h5A5A_C3C3, 1'b1);
        check("post_abort_idle", busy, 1'b0);

        // Reset in the middle of RX_CRC.
        begin_write();
        dat_in = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            dat_in = (i % 3 == 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            dat_in = 1'b1;
            step();
        end
        check("pre_reset_rx_crc", state_dbg, 4'd3);
        reset = 1'b1;
        #1;
        check("midrst_line", {dat_oe, dat_out}, 2'b01);
        check("midrst_flags", {busy, tx_ready, rx_valid, crc_error, timeout_error, done}, 6'b0);
        check("midrst_rx_data", rx_data, 32'h0);
        check("midrst_state", state_dbg, 4'd0);
        step();
        reset    = 1'b0;
        dat_in   = 1'b1;
        tx_valid = 1'b0;
        step();
        begin_write();
        send_block(32'hC0DE_1234, 16'h0000, 1'b1);
        reply(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
